mod_sysinfo: RTL
================

# mod_sysinfo

Memory-mapped system information and timekeeping peripheral on the PLP data bus, replacing the fixed two-word CPU ID block. It returns the CPU ID and board frequency, and adds a free-running 64-bit cycle counter with atomic high-word capture, an optional uptime-seconds counter, a control register and a parametrised bank of scratch registers. Software uses it for identification, benchmarking and coarse timekeeping.

## Interface
Parameters:
- `CPU_ID`, 32'h00000401: value returned at offset 0x00.
- `BOARD_FREQ`, 32'h017d7840 (25 MHz): clock frequency in Hz, returned at offset 0x04 and used as the seconds prescaler period; legal values are 1 to 2^32-1.
- `NUM_SCRATCH`, 2: number of read/write scratch words, legal range 1..8.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `ie`  in  1  instruction enable (unused).
- `de`  in  1  data enable; qualifies all data accesses.
- `iaddr`  in  32  instruction address (unused).
- `daddr`  in  32  data address; decoded on `daddr[7:2]`, other bits ignored.
- `drw`  in  2  `drw[0]` = write, `drw[1]` = read.
- `din`  in  32  write data.
- `iout`  out  32  tied to 0.
- `dout`  out  32  read data, combinational from `daddr` and the register state.

## Operation
Register map (byte offsets):
- 0x00 `CPU_ID` (read-only).
- 0x04 `BOARD_FREQ` (read-only).
- 0x08 `CYC_LO` (read-only): returns `cyc[31:0]`. An access with `de && drw[1]` at 0x08 loads `shadow_hi <= cyc[63:32]` on the clock edge.
- 0x0C `CYC_HI` (read-only): returns `shadow_hi`, not the live high word. Reading LO then HI gives a coherent 64-bit value.
- 0x10 `UPTIME` (read-only): seconds since reset or since the last clear.
- 0x14 `CTRL`:
  - bit0 `EN`: 1 = counters run.
  - bit1 `CLR`: write-only and self-clearing; always reads 0.
  - bits 31:2 read as 0.
- 0x20 + 4·i: `SCRATCH[i]`, read/write, for i < `NUM_SCRATCH`.
- Unmapped offsets and scratch offsets at or above `NUM_SCRATCH` read 0; writes to them are ignored.
- Writes to read-only offsets are ignored.

Counters:
- `cyc` is 64 bits and increments by 1 per cycle while `EN`=1. It wraps from 2^64-1 to 0.
- `presc` is 32 bits and counts 0..`BOARD_FREQ`-1. On the terminal count it returns to 0 and `uptime` (32 bits) increments by 1; `uptime` wraps to 0.
- All counters hold their value while `EN`=0.
- Writing `CTRL` with bit1=1 zeroes `cyc`, `presc`, `uptime` and `shadow_hi` on that edge. `EN` takes `din[0]` on the same write.

Priority per edge:
1. Reset.
2. Clear.
3. Shadow latch or increment.

If a read of 0x08 coincides with a clear, `shadow_hi` becomes 0.

Reset values (`rst`=0 at an edge):
- `cyc`=0, `presc`=0, `uptime`=0, `shadow_hi`=0.
- `EN`=1.
- All `SCRATCH`=0.
- `iout`=0.
- `dout` follows the decode (0x00 reads `CPU_ID` even while in reset).

## Timing
- Read latency is 0 cycles: `dout` is combinational. `dout` is 0 unless `de && drw[1]`.
- Write takes effect at the edge where `de && drw[0]`; the new value is visible on `dout` in the next cycle.
- `CYC_LO` returns the value before the current edge's increment. `shadow_hi` captures the high word from the same pre-edge value.
- The `EN` 0→1 write edge does not increment. Counting resumes on the following edge.
- Reset asserted mid-count is honoured at the next edge. The first increment happens on the first edge with `rst`=1.

## Configuration
- `SYSINFO_UPTIME_EN` defined: `presc` and `uptime` are built as described.
- `SYSINFO_UPTIME_EN` undefined: no prescaler or `uptime` logic is built. Offset 0x10 reads 0 and `CLR` affects only `cyc` and `shadow_hi`.

## Test plan
- **Reset ID/frequency:** hold `rst`=0 for 2 cycles, release, read 0x00 and 0x04 → 0x00000401 and 0x017d7840; read 0x14 → 0x00000001.
- **Coherent 64-bit read:** set `cyc`=0x00000000_FFFFFFFE by clearing then running 2^32-2 cycles (or a force). Read 0x08 → 0xFFFFFFFE. Wait 5 cycles, read 0x0C → 0x00000000, not 0x00000001.
- **Uptime:** with `BOARD_FREQ`=4 and `SYSINFO_UPTIME_EN` defined, after 10 cycles from reset 0x10 reads 2. With the macro undefined, 0x10 reads 0.
- **Enable and clear:** write 0x14=0, wait 20 cycles, read 0x08 → value unchanged. Write 0x14=0x3 → next read of 0x08 = 0, and 0x14 reads 0x1.
- **Scratch bounds:** with `NUM_SCRATCH`=2, write 0xDEADBEEF to 0x20 and 0x12345678 to 0x28. Read 0x20 → 0xDEADBEEF, 0x28 → 0. Writes to 0x00 and 0x04 leave them unchanged.
- **Read qualifier:** with `de`=0, or `drw`=2'b01, at 0x00 → `dout`=0; `iout`=0 throughout.

Source files
------------

// File: rtl/mod_sysinfo.sv
// rtl/mod_sysinfo.sv - system info, 64-bit cycle counter, uptime and scratch registers on the PLP data bus
// Optional uptime prescaler/counter built only when SYSINFO_UPTIME_EN is defined.
module mod_sysinfo #(
    parameter logic [31:0] CPU_ID      = 32'h00000401,
    parameter logic [31:0] BOARD_FREQ  = 32'h017d7840,
    parameter int          NUM_SCRATCH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ie,
    input  logic        de,
    input  logic [31:0] iaddr,
    input  logic [31:0] daddr,
    input  logic [1:0]  drw,
    input  logic [31:0] din,
    output logic [31:0] iout,
    output logic [31:0] dout
);

    logic [63:0] cyc;
    logic [31:0] shadow_hi;
    logic        en;
    logic [NUM_SCRATCH-1:0][31:0] scratch;
    logic [31:0] uptime_val;
    logic [31:0] rdata;

    logic [5:0] word;
    logic       rd_en;
    logic       wr_en;
    logic       ctrl_wr;
    logic       clr;
    logic       lo_rd;
    logic       unused_inputs;

    assign word    = daddr[7:2];
    assign rd_en   = de & drw[1];
    assign wr_en   = de & drw[0];
    assign ctrl_wr = wr_en && (word == 6'h05);
    assign clr     = ctrl_wr && din[1];
    assign lo_rd   = rd_en && (word == 6'h02);

    assign unused_inputs = ^{ie, iaddr, daddr[31:8], daddr[1:0]};
    assign iout = 32'd0;

    // Clear wins over both the shadow capture and the increment on the same edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cyc       <= 64'd0;
            shadow_hi <= 32'd0;
            en        <= 1'b1;
        end else begin
            if (ctrl_wr) begin
                en <= din[0];
            end
            if (clr) begin
                cyc       <= 64'd0;
                shadow_hi <= 32'd0;
            end else begin
                if (lo_rd) begin
                    shadow_hi <= cyc[63:32];
                end
                if (en) begin
                    cyc <= cyc + 64'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            scratch <= '0;
        end else begin
            for (int i = 0; i < NUM_SCRATCH; i++) begin
                if (wr_en && (word == 6'(8 + i))) begin
                    scratch[i] <= din;
                end
            end
        end
    end

`ifdef SYSINFO_UPTIME_EN
    logic [31:0] presc;
    logic [31:0] uptime;

    always_ff @(posedge clk) begin
        if (!rst) begin
            presc  <= 32'd0;
            uptime <= 32'd0;
        end else if (clr) begin
            presc  <= 32'd0;
            uptime <= 32'd0;
        end else if (en) begin
            if (presc == BOARD_FREQ - 32'd1) begin
                presc  <= 32'd0;
                uptime <= uptime + 32'd1;
            end else begin
                presc <= presc + 32'd1;
            end
        end
    end

    assign uptime_val = uptime;
`else
    assign uptime_val = 32'd0;
`endif

    always_comb begin
        rdata = 32'd0;
        case (word)
            6'h00:   rdata = CPU_ID;
            6'h01:   rdata = BOARD_FREQ;
            6'h02:   rdata = cyc[31:0];
            6'h03:   rdata = shadow_hi;
            6'h04:   rdata = uptime_val;
            6'h05:   rdata = {31'd0, en};
            default: rdata = 32'd0;
        endcase
        for (int i = 0; i < NUM_SCRATCH; i++) begin
            if (word == 6'(8 + i)) begin
                rdata = scratch[i];
            end
        end
    end

    assign dout = rd_en ? rdata : 32'd0;

endmodule
